// File: rtl/serial_subtractor_pkg.sv
// Shared types and sizing helpers for the bit-serial subtractor.
package serial_sub_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned CNT_W     = $clog2(DEF_WIDTH);

  // Bit-counter width for a given operand width (always at least 1 bit).
  function automatic int unsigned cnt_w(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester and the serial subtractor.
interface serial_subtractor_if #(parameter int unsigned WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;

  modport master (output start, a, b, bin, input busy, done, diff, bout);
  modport slave  (input start, a, b, bin, output busy, done, diff, bout);
endinterface

// File: rtl/serial_subtractor_fs.sv
// One-bit full subtractor cell: d = x - y - bi, bo = borrow out.
module fs (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);
  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: a - b - bin, LSB first, one bit per clock.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  serial_subtractor_if.slave bus
);
  localparam int unsigned CW = cnt_w(WIDTH);

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q;
  logic [WIDTH-2:0] diff_sh_q;
  logic [WIDTH-1:0] diff_q;
  logic             brw_q, bout_q;
  logic             d_w, bo_w;
  logic             accept, last;

  // DONE also accepts, which gives zero-gap back-to-back operation.
  assign accept = bus.start && (state_q != RUN);
  assign last   = (cnt_q == CW'(WIDTH - 1));

  fs u_fs (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (brw_q),
    .d  (d_w),
    .bo (bo_w)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? RUN : IDLE;
      RUN:     state_d = last ? DONE : RUN;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN);
    bus.done = (state_q == DONE);
    bus.diff = diff_q;
    bus.bout = bout_q;
  end

  // diff_sh holds the first WIDTH-1 result bits; the last bit joins on completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      brw_q     <= 1'b0;
      cnt_q     <= '0;
      diff_q    <= '0;
      bout_q    <= 1'b0;
    end else if (accept) begin
      a_sh_q <= bus.a;
      b_sh_q <= bus.b;
      brw_q  <= bus.bin;
      cnt_q  <= '0;
    end else if (state_q == RUN) begin
      a_sh_q    <= a_sh_q >> 1;
      b_sh_q    <= b_sh_q >> 1;
      diff_sh_q <= (WIDTH-1)'({d_w, diff_sh_q} >> 1);
      brw_q     <= bo_w;
      cnt_q     <= cnt_q + 1'b1;
      if (last) begin
        diff_q <= {d_w, diff_sh_q};
        bout_q <= bo_w;
      end
    end
  end
endmodule
